pipe_skid_reg: RTL and testbench

Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a WIDTH-bit stage payload using a valid/ready handshake on both sides. It contains a 2-entry skid buffer, so the upstream ready is a registered signal with no combinational ready path. It also provides prioritised flush/csr_flush, optional payload zeroing, and saturating performance counters.

---
 rtl/pipe_skid_reg.sv | 115 +++++++++++
 tb/tb_pipe_skid_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid pipeline register with flush and saturating perf counters
// The upstream ready comes straight from a flop, so no combinational path runs from out_ready to in_ready.
module pipe_skid_reg #(
   parameter int WIDTH      = 64,
   parameter bit CLEAR_DATA = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             csr_flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       level,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] kill_cnt
);

   logic [1:0]       level_q, level_d;
   logic             in_ready_q;
   logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic [CNT_W-1:0] stall_q, kill_q;
   logic [CNT_W:0]   kill_sum;
   logic [1:0]       kill_amt;
   logic             in_fire, out_fire, stall, kill_all;

   assign out_valid = (level_q != 2'd0);
   assign out_data  = main_q;
   assign in_ready  = in_ready_q;
   assign level     = level_q;
   assign stall_cnt = stall_q;
   assign kill_cnt  = kill_q;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;
   assign stall    = out_valid & ~out_ready;
   // csr_flush yields to backpressure; flush does not
   assign kill_all = flush | (csr_flush & ~stall);

   always_comb begin
      level_d = level_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (kill_all) begin
         level_d = 2'd0;
         if (CLEAR_DATA) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         case (level_q)
            2'd0: begin
               if (in_fire) begin
                  main_d  = in_data;
                  level_d = 2'd1;
               end
            end
            2'd1: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (out_fire) begin
                  level_d = 2'd0;
               end else if (in_fire) begin
                  skid_d  = in_data;
                  level_d = 2'd2;
               end
            end
            default: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  level_d = 2'd1;
               end
            end
         endcase
      end
   end

   // an entry leaving on the same edge as a csr_flush was delivered, not killed
   always_comb begin
      kill_amt = 2'd0;
      if (flush)
         kill_amt = level_q;
      else if (kill_all)
         kill_amt = level_q - {1'b0, out_fire};
   end

   assign kill_sum = {1'b0, kill_q} + (CNT_W+1)'(kill_amt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q    <= 2'd0;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
         stall_q    <= '0;
         kill_q     <= '0;
      end else begin
         level_q    <= level_d;
         in_ready_q <= (level_d != 2'd2);
         main_q     <= main_d;
         skid_q     <= skid_d;
         if (stall && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
         kill_q     <= kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
      end
   end

   a_no_fire_when_full: assert property (@(posedge clk) disable iff (reset)
      !(in_fire && (level_q == 2'd2)));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - vector table plus arrival-order scoreboard for pipe_skid_reg
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0, csr_flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_ready, out_valid;
   logic [63:0] out_data;
   logic [1:0]  level;
   logic [15:0] stall_cnt, kill_cnt;
   logic        s_in_ready, s_out_valid;
   logic [63:0] s_out_data;
   logic [1:0]  s_level;
   logic [3:0]  s_stall_cnt, s_kill_cnt;

   int errors = 0;
   int checks = 0;
   bit run = 1'b0;
   logic [63:0] sb[$];

   pipe_skid_reg #(.WIDTH(64), .CLEAR_DATA(1'b1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush), .csr_flush(csr_flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt));

   pipe_skid_reg #(.WIDTH(64), .CLEAR_DATA(1'b1), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush), .csr_flush(csr_flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .level(s_level), .stall_cnt(s_stall_cnt), .kill_cnt(s_kill_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [63:0] id;
      logic        ordy;
      logic        fl;
      logic        cf;
      logic [1:0]  e_lvl;
      logic        e_ov;
      logic        e_ir;
      logic        chk_d;
      logic [63:0] e_od;
      logic [15:0] e_stall;
      logic [15:0] e_kill;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Inputs are stable at the falling edge, so this sees exactly what the next rising edge will
   always @(negedge clk) begin
      if (run && !reset) begin
         chk("sb_level", {62'd0, level}, 64'(sb.size()));
         if (out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               chk("sb_data", out_data, sb.pop_front());
            end
         end
         if (flush || (csr_flush && !(out_valid && !out_ready)))
            sb.delete();
         else if (in_valid && in_ready)
            sb.push_back(in_data);
      end
   end

   always @(posedge reset) sb.delete();

   initial begin
      // streaming, 1-cycle lag, level stays 1
      for (int i = 1; i <= 8; i++)
         tbl.push_back('{1'b1, 64'(i), 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 64'(i), 16'd0, 16'd0});
      tbl.push_back('{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 64'h0,  16'd0, 16'd0});
      // backpressure fill, C refused while full, then drain in order
      tbl.push_back('{1'b1, 64'hA,  1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 64'hA,  16'd0, 16'd0});
      tbl.push_back('{1'b1, 64'hB,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 64'hA,  16'd1, 16'd0});
      tbl.push_back('{1'b1, 64'hC,  1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 64'hA,  16'd2, 16'd0});
      tbl.push_back('{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 64'hB,  16'd2, 16'd0});
      tbl.push_back('{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 64'h0,  16'd2, 16'd0});
      // flush while full and backpressured
      tbl.push_back('{1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 64'h11, 16'd2, 16'd0});
      tbl.push_back('{1'b1, 64'h12, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 64'h11, 16'd3, 16'd0});
      tbl.push_back('{1'b1, 64'h13, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 64'h0,  16'd4, 16'd2});
      // flush discards a same-cycle in_fire
      tbl.push_back('{1'b1, 64'h21, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 64'h21, 16'd4, 16'd2});
      tbl.push_back('{1'b1, 64'h22, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 64'h0,  16'd5, 16'd3});
      // csr_flush: ignored under backpressure, otherwise delivers the out_fire entry
      tbl.push_back('{1'b1, 64'h31, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 64'h31, 16'd5, 16'd3});
      tbl.push_back('{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 64'h31, 16'd6, 16'd3});
      tbl.push_back('{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 64'h0,  16'd6, 16'd3});
      tbl.push_back('{1'b1, 64'h41, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 64'h41, 16'd6, 16'd3});
      tbl.push_back('{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 64'h0,  16'd6, 16'd3});

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_level", {62'd0, level}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
      chk("rst_kill", {48'd0, kill_cnt}, 64'd0);
      run = 1'b1;

      foreach (tbl[i]) begin
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].id;
         out_ready = tbl[i].ordy;
         flush     = tbl[i].fl;
         csr_flush = tbl[i].cf;
         step();
         chk($sformatf("v%0d_level", i), {62'd0, level}, {62'd0, tbl[i].e_lvl});
         chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_ov});
         chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].e_ir});
         if (tbl[i].chk_d)
            chk($sformatf("v%0d_out_data", i), out_data, tbl[i].e_od);
         chk($sformatf("v%0d_stall", i), {48'd0, stall_cnt}, {48'd0, tbl[i].e_stall});
         chk($sformatf("v%0d_kill", i), {48'd0, kill_cnt}, {48'd0, tbl[i].e_kill});
      end
      flush = 1'b0;
      csr_flush = 1'b0;

      // asynchronous reset between edges while full
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 64'h51;
      step();
      in_data = 64'h52;
      step();
      chk("ar_full", {62'd0, level}, 64'd2);
      in_valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("ar_level", {62'd0, level}, 64'd0);
      chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
      chk("ar_stall", {48'd0, stall_cnt}, 64'd0);
      #1 reset = 1'b0;
      in_valid = 1'b1;
      in_data = 64'h55;
      out_ready = 1'b1;
      step();
      chk("ar_first_valid", {63'd0, out_valid}, 64'd1);
      chk("ar_first_data", out_data, 64'h55);
      in_valid = 1'b0;
      step();
      chk("ar_drained", {62'd0, level}, 64'd0);

      // stall counter saturation on the 4-bit instance
      in_valid = 1'b1;
      in_data = 64'h66;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (20) step();
      chk("sat_stall4", {60'd0, s_stall_cnt}, 64'd15);
      chk("sat_stall16", {48'd0, stall_cnt}, 64'd20);
      repeat (5) step();
      chk("sat_stall4_hold", {60'd0, s_stall_cnt}, 64'd15);
      chk("sat_stall16_more", {48'd0, stall_cnt}, 64'd25);
      out_ready = 1'b1;
      step();
      chk("sat_drain_data_gone", {62'd0, level}, 64'd0);
      step();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
